// File: rtl/load_timer_8bit.sv
// rtl/load_timer_8bit.sv - loadable down-counting timer with one-shot or periodic reload
module load_timer_8bit #(
   parameter int WIDTH       = 8,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] s,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             done_q, done_d;

   // State, count, period and done registers; rst wins over every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_q      <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         period_q <= period_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic: load beats abort beats count enable
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (load_val != '0) ? RUN : DONE;
      end else if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            RUN: begin
               if (!en)
                  state_d = HOLD;
               else if ((s_q == ONE) && !AUTO_RELOAD)
                  state_d = DONE;
            end
            HOLD: begin
               // Leaving HOLD only re-arms; the decrement waits for the next edge
               if (en)
                  state_d = RUN;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath: count value, latched period and the registered done pulse
   always_comb begin
      s_d      = s_q;
      period_d = period_q;
      done_d   = 1'b0;
      if (load) begin
         s_d      = load_val;
         period_d = load_val;
         // A zero load finishes immediately
         done_d   = (load_val == '0);
      end else if (!abort && (state_q == RUN) && en) begin
         if (s_q == ONE) begin
            // The step from 1 is intercepted so s never wraps below zero
            done_d = 1'b1;
            s_d    = AUTO_RELOAD ? period_q : '0;
         end else begin
            s_d = s_q - ONE;
         end
      end
   end

   // Outputs are decoded from registered state only
   always_comb begin
      s    = s_q;
      busy = (state_q == RUN) || (state_q == HOLD);
      done = done_q;
   end

endmodule

// File: tb/tb_load_timer_8bit.sv
// tb/tb_load_timer_8bit.sv - directed-vector bench for load_timer_8bit
module tb_load_timer_8bit;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] load_val;
   logic       en;
   logic       abort;
   logic [7:0] s_os, s_pr;
   logic       busy_os, busy_pr;
   logic       done_os, done_pr;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic       rst;
      logic       load;
      logic [7:0] load_val;
      logic       en;
      logic       abort;
      logic [7:0] exp_s;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   load_timer_8bit #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .abort(abort),
      .s(s_os), .busy(busy_os), .done(done_os)
   );

   load_timer_8bit #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_p (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .abort(abort),
      .s(s_pr), .busy(busy_pr), .done(done_pr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic add(input logic r, input logic ld, input logic [7:0] lv, input logic e,
                      input logic ab, input logic [7:0] es, input logic eb, input logic ed);
      vec_t v;
      v.rst = r; v.load = ld; v.load_val = lv; v.en = e; v.abort = ab;
      v.exp_s = es; v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic ld, input logic [7:0] lv, input logic e,
                        input logic ab);
      rst = r; load = ld; load_val = lv; en = e; abort = ab;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dones;
      int exp_s;
      rst = 1'b1; load = 1'b0; load_val = 8'd0; en = 1'b0; abort = 1'b0;

      //    rst ld  val   en  ab    s    busy done
      // one-shot load 4
      add(0, 1, 8'd4, 1, 0, 8'd4, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd3, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd2, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd1, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
      // pause at 3
      add(0, 1, 8'd6, 1, 0, 8'd6, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd5, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd4, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd3, 1, 0);
      add(0, 0, 8'd0, 0, 0, 8'd3, 1, 0);
      add(0, 0, 8'd0, 0, 0, 8'd3, 1, 0);
      add(0, 0, 8'd0, 0, 0, 8'd3, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd3, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd2, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd1, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
      // reload mid-count
      add(0, 1, 8'd8, 1, 0, 8'd8, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd7, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd6, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd5, 1, 0);
      add(0, 1, 8'd2, 1, 0, 8'd2, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd1, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
      // abort at 5
      add(0, 1, 8'd8, 1, 0, 8'd8, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd7, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd6, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd5, 1, 0);
      add(0, 0, 8'd0, 1, 1, 8'd5, 0, 0);
      add(0, 0, 8'd0, 1, 0, 8'd5, 0, 0);
      add(0, 0, 8'd0, 1, 0, 8'd5, 0, 0);
      // load beats abort
      add(0, 1, 8'd3, 1, 1, 8'd3, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd2, 1, 0);
      // load of zero
      add(0, 1, 8'd0, 1, 0, 8'd0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
      // rst together with load at s=3
      add(0, 1, 8'd5, 1, 0, 8'd5, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd4, 1, 0);
      add(0, 0, 8'd0, 1, 0, 8'd3, 1, 0);
      add(1, 1, 8'd9, 1, 0, 8'd0, 0, 0);
      add(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

      // reset for two cycles, then idle for ten
      drive(1, 0, 8'd0, 0, 0);
      drive(1, 0, 8'd0, 0, 0);
      check("rst_s", s_os, 0);
      check("rst_busy", busy_os, 0);
      check("rst_done", done_os, 0);
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 8'd0, 0, 0);
         check("idle_s", s_os, 0);
         check("idle_busy", busy_os, 0);
         check("idle_done", done_os, 0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].abort);
         check($sformatf("v%0d_s", i), s_os, vecs[i].exp_s);
         check($sformatf("v%0d_busy", i), busy_os, vecs[i].exp_busy);
         check($sformatf("v%0d_done", i), done_os, vecs[i].exp_done);
      end

      // full-range count from 255
      drive(0, 1, 8'd255, 1, 0);
      check("full_load_s", s_os, 255);
      for (int i = 1; i < 255; i++) begin
         drive(0, 0, 8'd0, 1, 0);
         check("full_s", s_os, 255 - i);
         check("full_done", done_os, 0);
      end
      drive(0, 0, 8'd0, 1, 0);
      check("full_end_s", s_os, 0);
      check("full_end_done", done_os, 1);
      check("full_end_busy", busy_os, 0);

      // periodic instance: period 4 over five periods
      drive(1, 0, 8'd0, 0, 0);
      check("per_rst_s", s_pr, 0);
      drive(0, 1, 8'd4, 1, 0);
      check("per_load_s", s_pr, 4);
      check("per_load_busy", busy_pr, 1);
      dones = 0;
      for (int i = 1; i <= 20; i++) begin
         drive(0, 0, 8'd0, 1, 0);
         exp_s = ((i % 4) == 0) ? 4 : 4 - (i % 4);
         check($sformatf("per%0d_s", i), s_pr, exp_s);
         check($sformatf("per%0d_busy", i), busy_pr, 1);
         check($sformatf("per%0d_done", i), done_pr, ((i % 4) == 0) ? 1 : 0);
         if (done_pr) dones++;
      end
      check("per_done_count", dones, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
